// File: rtl/led_sequencer_if.sv
// Board-side signal bundle for led_sequencer: raw switches/button in, LED bank and mode out.
// The sequencer takes the slave view; the board or testbench drives through the master view.
`timescale 1ns/1ps
interface led_sequencer_if;
   logic [7:0] switch;
   logic       btn;
   logic [7:0] led;
   logic [1:0] mode;

   modport master (output switch, output btn, input led, input mode);
   modport slave  (input switch, input btn, output led, output mode);
endinterface

// File: rtl/led_sequencer.sv
// 8-LED bank sequencer: debounced button steps PASS/CHASE/BLINK/COUNT, prescaled tick paces animation.
// Build macro LED_PWM_EN adds a 16-slot PWM dimmer (PWM_DUTY on-slots) after the LED register.
`timescale 1ns/1ps
module led_sequencer #(
   parameter int TICK_DIV   = 12500000,
   parameter int DEB_CYCLES = 250000,
   parameter int PWM_DUTY   = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   led_sequencer_if.slave bus
);
   localparam int TW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEB_CYCLES + 1);

   typedef enum logic [1:0] {
      S_PASS  = 2'd0,
      S_CHASE = 2'd1,
      S_BLINK = 2'd2,
      S_COUNT = 2'd3
   } state_t;

   if (TICK_DIV < 2 || DEB_CYCLES < 1 || PWM_DUTY < 0 || PWM_DUTY > 16) begin : g_param_check
      $error("led_sequencer: parameter out of range");
   end

   function automatic logic [7:0] rotl1(input logic [7:0] v);
      return {v[6:0], v[7]};
   endfunction

   // An all-dark chase would be invisible, so seed a single lit LED instead.
   function automatic logic [7:0] chase_seed(input logic [7:0] v);
      return (v == 8'h00) ? 8'h01 : v;
   endfunction

   logic [7:0]    r_sw_p0, r_sw_p1;
   logic          r_btn_p0, r_btn_p1;
   logic [7:0]    w_sw_s;
   logic          w_btn_s;
   logic [TW-1:0] r_tick_cnt;
   logic          w_tick;
   logic [DW-1:0] r_deb_cnt;
   logic          r_btn_db, r_btn_db_q;
   logic          r_rel_p0, r_rel_p1, r_armed;
   logic          w_deb_fire, w_adv;
   state_t        r_state, w_state_nxt;
   logic [7:0]    r_pat, w_pat_nxt;
   logic [7:0]    r_count, w_count_nxt;
   logic          r_shown, w_shown_nxt;
   logic [7:0]    r_led, w_led_nxt;

   // ---- stage p0/p1: two-flop synchronizers on the asynchronous board inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sw_p0  <= 8'h00;
         r_sw_p1  <= 8'h00;
         r_btn_p0 <= 1'b0;
         r_btn_p1 <= 1'b0;
      end else begin
         r_sw_p0  <= bus.switch;
         r_sw_p1  <= r_sw_p0;
         r_btn_p0 <= bus.btn;
         r_btn_p1 <= r_btn_p0;
      end
   end

   assign w_sw_s  = r_sw_p1;
   assign w_btn_s = r_btn_p1;

   assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + TW'(1);
      end
   end

   // ---- debounce: btn_db follows btn_s only after DEB_CYCLES consecutive mismatching samples
   assign w_deb_fire = (w_btn_s != r_btn_db) && (r_deb_cnt == DW'(DEB_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_deb_cnt  <= '0;
         r_btn_db   <= 1'b0;
         r_btn_db_q <= 1'b0;
      end else begin
         r_btn_db_q <= r_btn_db;
         if (w_btn_s == r_btn_db) begin
            r_deb_cnt <= '0;
         end else if (w_deb_fire) begin
            r_deb_cnt <= '0;
            r_btn_db  <= w_btn_s;
         end else begin
            r_deb_cnt <= r_deb_cnt + DW'(1);
         end
      end
   end

   // A button held through reset release must be seen released before any press counts;
   // r_rel_p1 marks when the synchronizer holds real post-reset samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rel_p0 <= 1'b0;
         r_rel_p1 <= 1'b0;
         r_armed  <= 1'b0;
      end else begin
         r_rel_p0 <= 1'b1;
         r_rel_p1 <= r_rel_p0;
         if (r_rel_p1 && !w_btn_s) begin
            r_armed <= 1'b1;
         end
      end
   end

   assign w_adv = r_btn_db & ~r_btn_db_q & r_armed;

   // ---- stage p2: mode FSM, pattern registers and the LED output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_PASS;
         r_pat   <= 8'h00;
         r_count <= 8'h00;
         r_shown <= 1'b1;
         r_led   <= 8'h00;
      end else begin
         r_state <= w_state_nxt;
         r_pat   <= w_pat_nxt;
         r_count <= w_count_nxt;
         r_shown <= w_shown_nxt;
         r_led   <= w_led_nxt;
      end
   end

   // A mode advance takes priority over a coincident tick; the new mode's entry action wins.
   always_comb begin
      w_state_nxt = r_state;
      w_pat_nxt   = r_pat;
      w_count_nxt = r_count;
      w_shown_nxt = r_shown;
      w_led_nxt   = r_led;
      if (w_adv) begin
         case (r_state)
            S_PASS: begin
               w_state_nxt = S_CHASE;
               w_pat_nxt   = chase_seed(w_sw_s);
            end
            S_CHASE: begin
               w_state_nxt = S_BLINK;
               w_pat_nxt   = w_sw_s;
               w_shown_nxt = 1'b1;
            end
            S_BLINK: begin
               w_state_nxt = S_COUNT;
               w_count_nxt = 8'h00;
            end
            S_COUNT: begin
               w_state_nxt = S_PASS;
            end
            default: ;
         endcase
      end else if (w_tick) begin
         case (r_state)
            S_CHASE: w_pat_nxt   = rotl1(r_pat);
            S_BLINK: w_shown_nxt = ~r_shown;
            S_COUNT: w_count_nxt = r_count + 8'd1;
            default: ;
         endcase
      end
      case (w_state_nxt)
         S_PASS:  w_led_nxt = w_sw_s;
         S_CHASE: w_led_nxt = w_pat_nxt;
         S_BLINK: w_led_nxt = w_shown_nxt ? w_pat_nxt : 8'h00;
         S_COUNT: w_led_nxt = w_count_nxt;
         default: w_led_nxt = 8'h00;
      endcase
   end

   assign bus.mode = r_state;

`ifdef LED_PWM_EN
   logic [3:0] r_pwm_cnt;
   logic [7:0] r_led_pwm;

   function automatic logic [7:0] pwm_gate(input logic [7:0] v, input logic [3:0] slot);
      return ({1'b0, slot} < 5'(PWM_DUTY)) ? v : 8'h00;
   endfunction

   // ---- stage p3: PWM dimming, one extra register of LED latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm_cnt <= 4'd0;
         r_led_pwm <= 8'h00;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 4'd1;
         r_led_pwm <= pwm_gate(r_led, r_pwm_cnt);
      end
   end

   assign bus.led = r_led_pwm;
`else
   assign bus.led = r_led;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer with TICK_DIV=4, DEB_CYCLES=3 (PWM_DUTY=4 when LED_PWM_EN is defined).
`timescale 1ns/1ps
module tb_led_sequencer;
   localparam int TICK_DIV   = 4;
   localparam int DEB_CYCLES = 3;
   localparam int PWM_DUTY   = 4;

   logic clk = 1'b0;
   logic rst_n;

   led_sequencer_if bus();

   led_sequencer #(
      .TICK_DIV  (TICK_DIV),
      .DEB_CYCLES(DEB_CYCLES),
      .PWM_DUTY  (PWM_DUTY)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] led;
      logic [1:0] mode;
      bit         chk_led;
   } exp_t;

   typedef struct {
      string      name;
      logic [7:0] sw;
      logic [7:0] exp_led;
      logic [1:0] exp_mode;
   } pvec_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   btn_busy = 1'b0;

   task automatic push_exp(input string name, input logic [7:0] led, input logic [1:0] mode,
                           input bit chk_led);
      exp_t e;
      e.name    = name;
      e.led     = led;
      e.mode    = mode;
      e.chk_led = chk_led;
      sb_q.push_back(e);
   endtask

   task automatic check_front();
      exp_t e;
      n_vec++;
      if (sb_q.size() == 0) begin
         n_err++;
         $display("FAIL sb_empty: no expected entry queued at %0t", $time);
         return;
      end
      e = sb_q.pop_front();
      if ((e.chk_led && (bus.led !== e.led)) || (bus.mode !== e.mode)) begin
         n_err++;
         $display("FAIL %s: led=%h mode=%0d, required led=%h mode=%0d%s", e.name, bus.led,
                  bus.mode, e.led, e.mode, e.chk_led ? "" : " (led not compared)");
      end
   endtask

   task automatic compare_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

`ifndef LED_PWM_EN
   // Bouncy press: 1,0,1,0 one cycle each, held 10 cycles, released 20 cycles.
   task automatic press();
      btn_busy = 1'b1;
      for (int i = 0; i < 34; i++) begin
         @(negedge clk);
         bus.btn = (i < 4) ? ((i % 2) == 0) : (i < 14);
      end
      btn_busy = 1'b0;
   endtask

   task automatic wait_press_done();
      while (btn_busy) @(negedge clk);
   endtask

   task automatic wait_mode(input string name, input logic [1:0] m, input logic [7:0] led,
                            input bit chk_led);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.mode == m) break;
      end
      push_exp(name, led, m, chk_led);
      check_front();
   endtask

   task automatic press_into(input string name, input logic [1:0] m, input logic [7:0] led,
                             input bit chk_led);
      fork
         press();
      join_none
      wait_mode(name, m, led, chk_led);
   endtask

   // Waits (bounded) for the LED value to change, then checks the new value and the spacing.
   task automatic expect_next(input string name, input logic [7:0] exp_led,
                              input logic [1:0] exp_mode, input int exp_gap);
      logic [7:0] last;
      int         gap;
      last = bus.led;
      gap  = 0;
      for (int k = 1; k <= 3 * TICK_DIV; k++) begin
         @(negedge clk);
         gap = k;
         if (bus.led != last) break;
      end
      push_exp(name, exp_led, exp_mode, 1'b1);
      check_front();
      if (exp_gap > 0) compare_int({name, "_gap"}, gap, exp_gap);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pass_latency(input string name, input logic [7:0] sw, input logic [7:0] old_led,
                               input logic [7:0] new_led);
      @(negedge clk);
      bus.switch = sw;
      push_exp({name, "_hold"}, old_led, 2'd0, 1'b1);
      push_exp(name, new_led, 2'd0, 1'b1);
      repeat (2) @(posedge clk);
      #1 check_front();
      @(posedge clk);
      #1 check_front();
   endtask

   task automatic run_full();
      pvec_t      vec[6];
      logic [7:0] prev;
      vec[0] = '{name: "pass_5a", sw: 8'h5A, exp_led: 8'h5A, exp_mode: 2'd0};
      vec[1] = '{name: "pass_00", sw: 8'h00, exp_led: 8'h00, exp_mode: 2'd0};
      vec[2] = '{name: "pass_ff", sw: 8'hFF, exp_led: 8'hFF, exp_mode: 2'd0};
      vec[3] = '{name: "pass_3c", sw: 8'h3C, exp_led: 8'h3C, exp_mode: 2'd0};
      vec[4] = '{name: "pass_81", sw: 8'h81, exp_led: 8'h81, exp_mode: 2'd0};
      vec[5] = '{name: "pass_a5", sw: 8'hA5, exp_led: 8'hA5, exp_mode: 2'd0};

      // Reset with switch=A5 applied: dark during reset, A5 on the 3rd edge after release.
      repeat (3) @(negedge clk);
      push_exp("reset_led", 8'h00, 2'd0, 1'b1);
      check_front();
      rst_n = 1'b1;
      push_exp("rst_rel_e2", 8'h00, 2'd0, 1'b1);
      push_exp("rst_rel_e3", 8'hA5, 2'd0, 1'b1);
      repeat (2) @(posedge clk);
      #1 check_front();
      @(posedge clk);
      #1 check_front();

      prev = 8'hA5;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.switch = vec[i].sw;
         push_exp({vec[i].name, "_hold"}, prev, vec[i].exp_mode, 1'b1);
         push_exp(vec[i].name, vec[i].exp_led, vec[i].exp_mode, 1'b1);
         repeat (2) @(posedge clk);
         #1 check_front();
         @(posedge clk);
         #1 check_front();
         prev = vec[i].exp_led;
      end

      // CHASE from A5
      press_into("chase_entry", 2'd1, 8'hA5, 1'b1);
      expect_next("chase_1", 8'h4B, 2'd1, 0);
      expect_next("chase_2", 8'h96, 2'd1, TICK_DIV);
      expect_next("chase_3", 8'h2D, 2'd1, TICK_DIV);
      wait_press_done();
      push_exp("chase_one_adv", 8'h00, 2'd1, 1'b0);
      check_front();

      // CHASE seeded from all-zero switches, full wrap
      do_reset();
      bus.switch = 8'h00;
      repeat (4) @(negedge clk);
      push_exp("pass_zero", 8'h00, 2'd0, 1'b1);
      check_front();
      press_into("chase0_entry", 2'd1, 8'h01, 1'b1);
      for (int s = 1; s <= 8; s++) begin
         expect_next($sformatf("chase0_%0d", s), 8'(1 << (s % 8)), 2'd1, (s == 1) ? 0 : TICK_DIV);
      end
      wait_press_done();
      push_exp("chase0_one_adv", 8'h00, 2'd1, 1'b0);
      check_front();

      // BLINK with pattern latched at entry
      do_reset();
      bus.switch = 8'h3C;
      repeat (4) @(negedge clk);
      press_into("p1_chase", 2'd1, 8'h3C, 1'b1);
      wait_press_done();
      press_into("blink_entry", 2'd2, 8'h3C, 1'b1);
      expect_next("blink_1", 8'h00, 2'd2, 0);
      expect_next("blink_2", 8'h3C, 2'd2, TICK_DIV);
      bus.switch = 8'hFF;
      expect_next("blink_3", 8'h00, 2'd2, TICK_DIV);
      expect_next("blink_4", 8'h3C, 2'd2, TICK_DIV);
      expect_next("blink_5", 8'h00, 2'd2, TICK_DIV);
      expect_next("blink_6", 8'h3C, 2'd2, TICK_DIV);
      wait_press_done();
      push_exp("blink_one_adv", 8'h00, 2'd2, 1'b0);
      check_front();

      // COUNT with 8-bit wrap
      press_into("count_entry", 2'd3, 8'h00, 1'b1);
      for (int v = 1; v <= 256; v++) begin
         expect_next($sformatf("count_%0d", v), 8'(v), 2'd3, (v == 1) ? 0 : TICK_DIV);
      end
      expect_next("count_p1", 8'h01, 2'd3, TICK_DIV);
      expect_next("count_p2", 8'h02, 2'd3, TICK_DIV);

      // Asynchronous reset mid-count, checked before the next clock edge
      #2 rst_n = 1'b0;
      #1 push_exp("async_reset", 8'h00, 2'd0, 1'b1);
      check_front();

      // Button held through reset release must not advance the mode
      bus.btn = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      push_exp("held_thru_reset", 8'hFF, 2'd0, 1'b1);
      check_front();
      bus.btn = 1'b0;
      repeat (15) @(negedge clk);
      push_exp("held_released", 8'hFF, 2'd0, 1'b1);
      check_front();

      press_into("after_held", 2'd1, 8'hFF, 1'b1);
      wait_press_done();
      bus.switch = 8'hC3;
      repeat (4) @(negedge clk);
      press_into("cycle_blink", 2'd2, 8'hC3, 1'b1);
      wait_press_done();
      press_into("cycle_count", 2'd3, 8'h00, 1'b1);
      wait_press_done();
      press_into("back_to_pass", 2'd0, 8'hC3, 1'b1);
      wait_press_done();
      pass_latency("pass_again_5a", 8'h5A, 8'hC3, 8'h5A);
   endtask
`else
   task automatic run_pwm();
      int on;
      repeat (3) @(negedge clk);
      push_exp("pwm_reset", 8'h00, 2'd0, 1'b1);
      check_front();
      rst_n = 1'b1;
      bus.switch = 8'hFF;
      repeat (12) @(negedge clk);
      on = 0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         if (bus.led == 8'hFF) begin
            on++;
         end else begin
            push_exp($sformatf("pwm_off_%0d", k), 8'h00, 2'd0, 1'b1);
            check_front();
         end
      end
      compare_int("pwm_on_slots", on, (32 * PWM_DUTY) / 16);
   endtask
`endif

   initial begin
      rst_n      = 1'b0;
      bus.switch = 8'hA5;
      bus.btn    = 1'b0;
`ifdef LED_PWM_EN
      run_pwm();
`else
      run_full();
`endif
      if (sb_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL sb_leftover: %0d expected entries never compared", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time budget exhausted, vectors=%0d miscompares=%0d", n_vec, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
